// File: rtl/zc_freq_est.sv
// Zero-crossing frequency estimator: hysteresis crossing detector, per-frame crossing count.
// Define ZC_FREQ_EST_PERIOD_EN to build the crossing-interval tracker (o_period/o_period_v).
//
// state      | meaning
// UNARMED    | no sample has left the dead band since reset/clear
// LOW        | last out-of-band sample was below -thr
// HIGH       | last out-of-band sample was above +thr
module zc_freq_est #(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 16,
    parameter int FRAME_LEN = 256,
    parameter int EDGE_MODE = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic                    i_v,
    input  logic [WIDTH-2:0]        i_threshold,
    output logic [CNT_W-1:0]        o_count,
    output logic                    o_vout,
    output logic                    o_sat,
    output logic [CNT_W-1:0]        o_period,
    output logic                    o_period_v
);
    localparam int POS_W = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_UNARMED = 2'd0;
    localparam logic [1:0] ST_LOW     = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;

    logic signed [WIDTH-1:0] r_s1_x;
    logic                    r_s1_v;
    logic                    r_s2_v;
    logic                    r_s2_above;
    logic                    r_s2_below;
    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_acc;
    logic                    r_sat_flag;
    logic [POS_W-1:0]        r_pos;
    logic [CNT_W-1:0]        r_count;
    logic                    r_sat;
    logic                    r_vout;

    logic signed [WIDTH-1:0] w_pthr;
    logic signed [WIDTH-1:0] w_nthr;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_hit;
    logic                    w_acc_full;
    logic                    w_sat_hit;
    logic [CNT_W-1:0]        w_acc_next;
    logic [1:0]              w_state_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_x <= '0;
            r_s1_v <= 1'b0;
        end else if (i_clear) begin
            r_s1_v <= 1'b0;
        end else begin
            r_s1_v <= i_v;
            if (i_v) r_s1_x <= i_x;
        end
    end

    // Threshold is a non-negative magnitude; the zero-extended value always fits as a positive signed number.
    assign w_pthr = $signed({1'b0, i_threshold});
    assign w_nthr = -w_pthr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_v     <= 1'b0;
            r_s2_above <= 1'b0;
            r_s2_below <= 1'b0;
        end else if (i_clear) begin
            r_s2_v     <= 1'b0;
        end else begin
            r_s2_v     <= r_s1_v;
            r_s2_above <= r_s1_x > w_pthr;
            r_s2_below <= r_s1_x < w_nthr;
        end
    end

    assign w_rise = r_s2_v && (r_state == ST_LOW)  && r_s2_above;
    assign w_fall = r_s2_v && (r_state == ST_HIGH) && r_s2_below;
    assign w_hit  = (EDGE_MODE == 0) ? w_rise :
                    (EDGE_MODE == 1) ? w_fall : (w_rise | w_fall);

    assign w_acc_full = (r_acc == CNT_MAX);
    assign w_sat_hit  = w_hit && w_acc_full;
    assign w_acc_next = (w_hit && !w_acc_full) ? r_acc + CNT_W'(1) : r_acc;

    always_comb begin
        w_state_next = r_state;
        if (r_s2_v) begin
            case (r_state)
                ST_UNARMED: begin
                    if (r_s2_below)      w_state_next = ST_LOW;
                    else if (r_s2_above) w_state_next = ST_HIGH;
                end
                ST_LOW:  if (r_s2_above) w_state_next = ST_HIGH;
                ST_HIGH: if (r_s2_below) w_state_next = ST_LOW;
                default: w_state_next = ST_UNARMED;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_UNARMED;
            r_acc      <= '0;
            r_sat_flag <= 1'b0;
            r_pos      <= '0;
            r_count    <= '0;
            r_sat      <= 1'b0;
            r_vout     <= 1'b0;
        end else if (i_clear) begin
            r_state    <= ST_UNARMED;
            r_acc      <= '0;
            r_sat_flag <= 1'b0;
            r_pos      <= '0;
            r_vout     <= 1'b0;
        end else begin
            r_vout  <= 1'b0;
            r_state <= w_state_next;
            if (r_s2_v) begin
                // A crossing on the last sample is folded into the finishing frame.
                if (r_pos == POS_LAST) begin
                    r_count    <= w_acc_next;
                    r_sat      <= r_sat_flag | w_sat_hit;
                    r_vout     <= 1'b1;
                    r_acc      <= '0;
                    r_sat_flag <= 1'b0;
                    r_pos      <= '0;
                end else begin
                    r_acc      <= w_acc_next;
                    r_sat_flag <= r_sat_flag | w_sat_hit;
                    r_pos      <= r_pos + POS_W'(1);
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;
    assign o_vout  = r_vout;

`ifdef ZC_FREQ_EST_PERIOD_EN
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_period;
    logic             r_period_v;
    logic             r_armed;
    logic [CNT_W-1:0] w_gap_inc;

    assign w_gap_inc = (r_gap == CNT_MAX) ? r_gap : r_gap + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap      <= '0;
            r_period   <= '0;
            r_period_v <= 1'b0;
            r_armed    <= 1'b0;
        end else if (i_clear) begin
            r_gap      <= '0;
            r_period_v <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_period_v <= 1'b0;
            if (w_hit) begin
                // The first crossing only establishes a reference point.
                if (r_armed) begin
                    r_period   <= w_gap_inc;
                    r_period_v <= 1'b1;
                end
                r_armed <= 1'b1;
                r_gap   <= '0;
            end else if (r_s2_v) begin
                r_gap <= w_gap_inc;
            end
        end
    end

    assign o_period   = r_period;
    assign o_period_v = r_period_v;
`else
    assign o_period   = '0;
    assign o_period_v = 1'b0;
`endif
endmodule

// File: tb/tb_zc_freq_est.sv
// Bench for zc_freq_est: four instances (rising, falling, both, 3-bit saturating) share one
// stimulus stream and are checked every cycle against a sample-index based reference model.
`timescale 1ns/1ps
module tb_zc_freq_est;
    localparam int FL = 64;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic               v     = 1'b0;
    logic signed [15:0] x     = '0;
    logic [14:0]        thr   = 15'd500;

    logic [15:0] c0, c1, c2, p0, p1, p2;
    logic [2:0]  c3, p3;
    logic        vo0, vo1, vo2, vo3, s0, s1, s2, s3, pv0, pv1, pv2, pv3;
    logic [15:0] cnt_a [4];
    logic [15:0] per_a [4];
    logic        vout_a[4];
    logic        sat_a [4];
    logic        pv_a  [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    zc_freq_est #(.WIDTH(16), .CNT_W(16), .FRAME_LEN(FL), .EDGE_MODE(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_x(x), .i_v(v), .i_threshold(thr),
        .o_count(c0), .o_vout(vo0), .o_sat(s0), .o_period(p0), .o_period_v(pv0));
    zc_freq_est #(.WIDTH(16), .CNT_W(16), .FRAME_LEN(FL), .EDGE_MODE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_x(x), .i_v(v), .i_threshold(thr),
        .o_count(c1), .o_vout(vo1), .o_sat(s1), .o_period(p1), .o_period_v(pv1));
    zc_freq_est #(.WIDTH(16), .CNT_W(16), .FRAME_LEN(FL), .EDGE_MODE(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_x(x), .i_v(v), .i_threshold(thr),
        .o_count(c2), .o_vout(vo2), .o_sat(s2), .o_period(p2), .o_period_v(pv2));
    zc_freq_est #(.WIDTH(16), .CNT_W(3), .FRAME_LEN(FL), .EDGE_MODE(2)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_x(x), .i_v(v), .i_threshold(thr),
        .o_count(c3), .o_vout(vo3), .o_sat(s3), .o_period(p3), .o_period_v(pv3));

    assign cnt_a[0] = c0;  assign cnt_a[1] = c1;  assign cnt_a[2] = c2;  assign cnt_a[3] = {13'd0, c3};
    assign per_a[0] = p0;  assign per_a[1] = p1;  assign per_a[2] = p2;  assign per_a[3] = {13'd0, p3};
    assign vout_a[0] = vo0; assign vout_a[1] = vo1; assign vout_a[2] = vo2; assign vout_a[3] = vo3;
    assign sat_a[0] = s0;  assign sat_a[1] = s1;  assign sat_a[2] = s2;  assign sat_a[3] = s3;
    assign pv_a[0] = pv0;  assign pv_a[1] = pv1;  assign pv_a[2] = pv2;  assign pv_a[3] = pv3;

    // Reference model: crossings are recorded by global sample index; a frame's count is the number
    // of counted crossings clipped to the counter range, a period is an index difference, clipped.
    int EM[4] = '{0, 1, 2, 2};
    int MX[4] = '{65535, 65535, 65535, 7};
    int cyc    = 0;
    int m_side = 0;
    int m_pos  = 0;
    int m_idx  = 0;
    int m_fc  [4];
    int m_last[4] = '{-1, -1, -1, -1};
    bit pd_v  [4];
    int pd_cnt[4][4];
    bit pd_sat[4][4];
    bit pd_pv [4][4];
    int pd_per[4][4];

    function automatic int clip(input int a, input int m);
        return (a > m) ? m : a;
    endfunction

    function automatic void model_sample(input int xs, input int th, input int s);
        bit above, below, rise, fall, hit;
        above = xs > th;
        below = xs < -th;
        rise  = (m_side < 0) && above;
        fall  = (m_side > 0) && below;
        if (above) m_side = 1;
        else if (below) m_side = -1;
        for (int k = 0; k < 4; k++) begin
            hit = (EM[k] == 0) ? rise : (EM[k] == 1) ? fall : (rise | fall);
            if (hit) begin
                m_fc[k]++;
                if (m_last[k] >= 0) begin
                    pd_pv[s][k]  = 1'b1;
                    pd_per[s][k] = clip(m_idx - m_last[k], MX[k]);
                end
                m_last[k] = m_idx;
            end
            if (m_pos == FL - 1) begin
                pd_cnt[s][k] = clip(m_fc[k], MX[k]);
                pd_sat[s][k] = m_fc[k] > MX[k];
                m_fc[k] = 0;
            end
        end
        if (m_pos == FL - 1) pd_v[s] = 1'b1;
        m_pos = (m_pos + 1) % FL;
        m_idx++;
    endfunction

    always @(posedge clk) begin
        int s;
        cyc = cyc + 1;
        s = (cyc + 2) % 4;
        pd_v[s] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pd_cnt[s][k] = 0; pd_sat[s][k] = 1'b0; pd_pv[s][k] = 1'b0; pd_per[s][k] = 0;
        end
        if (!rst_n || clear) begin
            for (int j = 0; j < 4; j++) begin
                pd_v[j] = 1'b0;
                for (int k = 0; k < 4; k++) pd_pv[j][k] = 1'b0;
            end
            m_side = 0; m_pos = 0; m_idx = 0;
            for (int k = 0; k < 4; k++) begin m_fc[k] = 0; m_last[k] = -1; end
        end else if (v) begin
            model_sample(int'(x), int'(thr), s);
        end
    end

    int exp_cnt[4];
    bit exp_sat[4];
    int exp_per[4];
    int nv0 = 0, vt_prev = 0, vt_last = 0, npv = 0;

    task automatic monitor();
        forever begin
            int s;
            bit epv;
            @(posedge clk);
            #1;
            s = cyc % 4;
            for (int k = 0; k < 4; k++) begin
                if (!rst_n) begin exp_cnt[k] = 0; exp_sat[k] = 1'b0; exp_per[k] = 0; end
                if (pd_v[s]) begin exp_cnt[k] = pd_cnt[s][k]; exp_sat[k] = pd_sat[s][k]; end
`ifdef ZC_FREQ_EST_PERIOD_EN
                epv = pd_pv[s][k];
                if (epv) exp_per[k] = pd_per[s][k];
`else
                epv = 1'b0;
`endif
                n_chk += 5;
                if (vout_a[k] !== pd_v[s]) begin
                    n_fail++; $display("FAIL vout dut%0d cyc %0d: got %b want %b", k, cyc, vout_a[k], pd_v[s]);
                end
                if (cnt_a[k] !== 16'(exp_cnt[k])) begin
                    n_fail++; $display("FAIL count dut%0d cyc %0d: got %0d want %0d", k, cyc, cnt_a[k], exp_cnt[k]);
                end
                if (sat_a[k] !== exp_sat[k]) begin
                    n_fail++; $display("FAIL sat dut%0d cyc %0d: got %b want %b", k, cyc, sat_a[k], exp_sat[k]);
                end
                if (pv_a[k] !== epv) begin
                    n_fail++; $display("FAIL period_v dut%0d cyc %0d: got %b want %b", k, cyc, pv_a[k], epv);
                end
                if (per_a[k] !== 16'(exp_per[k])) begin
                    n_fail++; $display("FAIL period dut%0d cyc %0d: got %0d want %0d", k, cyc, per_a[k], exp_per[k]);
                end
                if (pv_a[k] === 1'b1) npv++;
            end
            if (vout_a[0] === 1'b1) begin nv0++; vt_prev = vt_last; vt_last = cyc; end
        end
    endtask

    task automatic put(input int xs, input bit vv, input bit clr = 1'b0);
        @(negedge clk);
        x = 16'(xs); v = vv; clear = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(0, 1'b0);
    endtask

    function automatic int sq(input int i, input int per);
        int amp;
        amp = int'($urandom_range(600, 3000));
        return ((i % per) < per / 2) ? amp : -amp;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (cnt_a[k] !== 16'd0 || vout_a[k] !== 1'b0 || sat_a[k] !== 1'b0 ||
                per_a[k] !== 16'd0 || pv_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: count %0d vout %b sat %b period %0d period_v %b want all 0",
                         k, cnt_a[k], vout_a[k], sat_a[k], per_a[k], pv_a[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_square();
        int want_c[4] = '{4, 4, 8, 7};
        int want_p[4] = '{16, 16, 8, 7};
        thr = 15'd500;
        for (int i = 0; i < 5 * FL; i++) put(sq(i, 16), 1'b1);
        idle(4);
        for (int k = 0; k < 4; k++) begin
            n_chk += 2;
            if (cnt_a[k] !== 16'(want_c[k])) begin
                n_fail++; $display("FAIL square_count dut%0d: got %0d want %0d", k, cnt_a[k], want_c[k]);
            end
            if (sat_a[k] !== (k == 3)) begin
                n_fail++; $display("FAIL square_sat dut%0d: got %b want %b", k, sat_a[k], k == 3);
            end
`ifdef ZC_FREQ_EST_PERIOD_EN
            if (per_a[k] !== 16'(want_p[k])) begin
`else
            if (per_a[k] !== 16'd0 || want_p[k] == 0) begin
`endif
                n_fail++; $display("FAIL square_period dut%0d: got %0d", k, per_a[k]);
            end
        end
        n_chk++;
        if (vt_last - vt_prev !== FL) begin
            n_fail++; $display("FAIL square_vout_spacing: got %0d want %0d", vt_last - vt_prev, FL);
        end
    endtask

    task automatic test_saturate();
        idle(3);
        put(0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3 * FL; i++) put(sq(i, 2), 1'b1);
        idle(4);
        n_chk += 3;
        if (c3 !== 3'd7 || s3 !== 1'b1) begin
            n_fail++; $display("FAIL sat3_count: got %0d sat %b want 7 sat 1", c3, s3);
        end
        if (c2 !== 16'd64 || s2 !== 1'b0) begin
            n_fail++; $display("FAIL fast_both_count: got %0d sat %b want 64 sat 0", c2, s2);
        end
        if (c0 !== 16'd32) begin
            n_fail++; $display("FAIL fast_rise_count: got %0d want 32", c0);
        end
    endtask

    task automatic test_noise();
        int pv_start, nv_start;
        thr = 15'd500;
        pv_start = npv;
        nv_start = nv0;
        for (int i = 0; i < 4 * FL; i++) put(int'($urandom_range(0, 800)) - 400, 1'b1);
        idle(4);
        n_chk += 2;
        if (nv0 - nv_start !== 4) begin
            n_fail++; $display("FAIL noise_vouts: got %0d want 4", nv0 - nv_start);
        end
        if (c0 !== 16'd0 || c2 !== 16'd0 || c3 !== 3'd0 || s3 !== 1'b0) begin
            n_fail++; $display("FAIL noise_count: got %0d/%0d/%0d sat3 %b want 0", c0, c2, c3, s3);
        end
        for (int i = 0; i < 8 * FL; i++) put(int'($urandom_range(0, 800)) - 400, (i % 2) == 0);
        idle(4);
        n_chk += 3;
        if (vt_last - vt_prev !== 2 * FL) begin
            n_fail++; $display("FAIL noise_toggle_spacing: got %0d want %0d", vt_last - vt_prev, 2 * FL);
        end
        if (c0 !== 16'd0 || c2 !== 16'd0) begin
            n_fail++; $display("FAIL noise_toggle_count: got %0d/%0d want 0", c0, c2);
        end
        if (npv !== pv_start) begin
            n_fail++; $display("FAIL noise_period_v: got %0d pulses want 0", npv - pv_start);
        end
    endtask

    task automatic test_random();
        int nvalid, pos0, nv_start;
        bit vv;
        idle(3);
        pos0 = m_pos;
        nv_start = nv0;
        nvalid = 0;
        for (int b = 0; b < 4; b++) begin
            idle(3);
            thr = 15'($urandom_range(0, 2500));
            for (int i = 0; i < 500; i++) begin
                vv = ($urandom_range(0, 3) != 0);
                if (vv) nvalid++;
                put(int'($urandom_range(0, 6000)) - 3000, vv);
            end
        end
        idle(4);
        n_chk++;
        if (nv0 - nv_start !== (pos0 + nvalid) / FL) begin
            n_fail++; $display("FAIL random_vouts: got %0d want %0d", nv0 - nv_start, (pos0 + nvalid) / FL);
        end
        thr = 15'd500;
    endtask

    task automatic test_restart(input bit use_rst);
        int nv_start;
        idle(3);
        put(0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 30; i++) put(sq(i, 16), 1'b1);
        idle(2);
        nv_start = nv0;
        if (use_rst) begin
            @(negedge clk); rst_n = 1'b0;
            idle(2);
            @(negedge clk); rst_n = 1'b1;
            n_chk++;
            if (c0 !== 16'd0 || c2 !== 16'd0) begin
                n_fail++; $display("FAIL rst_mid_count: got %0d/%0d want 0", c0, c2);
            end
        end else begin
            put(0, 1'b0, 1'b1);
        end
        idle(1);
        for (int i = 0; i < FL - 1; i++) put(sq(i + 5, 16), 1'b1);
        idle(3);
        n_chk++;
        if (nv0 !== nv_start) begin
            n_fail++; $display("FAIL restart_early_vout rst=%0d: got %0d vouts want 0", use_rst, nv0 - nv_start);
        end
        put(sq(FL + 4, 16), 1'b1);
        idle(3);
        n_chk++;
        if (nv0 !== nv_start + 1) begin
            n_fail++; $display("FAIL restart_vout rst=%0d: got %0d vouts want 1", use_rst, nv0 - nv_start);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_square();
        test_saturate();
        test_noise();
        test_random();
        test_restart(1'b0);
        test_restart(1'b1);
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
